uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter: CLKS_PER_BIT, default 4, clock cycles per serial bit; SHALL be at least 4.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 resetn  input  1  asynchronous, active-low reset.
REQ-004 rx_i  input  1  serial line, idle high, asynchronous to clk.
REQ-005 d_o  output  8  last correctly framed byte, LSB received first.
REQ-006 v_o  output  1  one-cycle pulse: d_o updated with a new byte.
REQ-007 frame_err_o  output  1  one-cycle pulse: stop bit sampled low.
REQ-008 busy_o  output  1  high whenever state is not IDLE.

Function
REQ-009 rx_i SHALL pass through a 2-flop synchronizer (rx_s); all decisions use rx_s only, so line-to-rx_s latency is 2 cycles.
REQ-010 States SHALL be IDLE, START, DATA, STOP, WAIT_IDLE; the 3-bit encoding is free; unused encodings go to IDLE next cycle.
REQ-011 IDLE: if rx_s==0 in cycle T0, go to START; the half-bit counter is loaded so the start check falls on cycle T0 + CLKS_PER_BIT/2 (integer division).
REQ-012 START check: sample 0 -> DATA; sample 1 -> IDLE (false start, no pulse).
REQ-013 DATA: bit k (k=0..7) SHALL be sampled at T0 + CLKS_PER_BIT/2 + (k+1)*CLKS_PER_BIT and shifted into a shift register LSB-first; after k=7 go to STOP.
REQ-014 STOP: stop bit sampled at T0 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT.
REQ-015 Stop sample 1: next cycle d_o <= shift register, v_o=1 for exactly one cycle, state -> IDLE.
REQ-016 Stop sample 0: next cycle frame_err_o=1 for one cycle; d_o unchanged; state -> WAIT_IDLE.
REQ-017 WAIT_IDLE: stay until rx_s==1, then go to IDLE; no new frame SHALL start while in WAIT_IDLE.
REQ-018 v_o and frame_err_o SHALL never be high in the same cycle.
REQ-019 Back-to-back frames: a start edge in the cycle after the stop-sample cycle SHALL be detected; there is no dead time beyond the IDLE check.
REQ-020 No backpressure: a consumer that misses a v_o pulse loses that byte; d_o holds its value until the next valid frame.
REQ-021 Bit counter and timer SHALL be sized with $clog2(CLKS_PER_BIT)+1 bits; no wrap-around inside a bit period.

Reset
REQ-022 On resetn low, immediately and asynchronously: state=IDLE, synchronizer flops=1, shift register=0, d_o=0, v_o=0, frame_err_o=0, busy_o=0, counters=0.
REQ-023 Reset mid-frame SHALL abort the frame with no v_o or frame_err_o pulse.
REQ-024 If rx_i is low when reset is released, it SHALL be treated as a start bit 2 cycles later.

Configuration
REQ-025 Macro UART_RX_MAJORITY_EN: when defined, each START, DATA and STOP sample SHALL be the 2-of-3 majority of rx_s in cycles S-2, S-1 and S, where S is the sample cycle.
REQ-026 Without UART_RX_MAJORITY_EN, each sample SHALL be rx_s in cycle S only; all other timing is identical in both builds.

Verification (CLKS_PER_BIT=4)
REQ-027 Scenario: drive 0xA5 as start, 8 data bits, stop, each 4 cycles -> one v_o pulse 2+2+36+1 cycles after rx_i falls, d_o=0xA5, frame_err_o never high.
REQ-028 Scenario: 0x00 then 0xFF back-to-back with no idle gap -> two v_o pulses 40 cycles apart, d_o=0x00 then 0xFF.
REQ-029 Scenario: 1-cycle low glitch on idle line -> START then IDLE, no v_o, busy_o high for at most 4 cycles.
REQ-030 Scenario: frame 0x3C with stop bit low, line held low 20 cycles then high -> one frame_err_o pulse, d_o keeps prior value, busy_o stays high until rx_s returns high.
REQ-031 Scenario: resetn pulsed low mid-data-bit 3 -> outputs zero within the reset cycle, no pulses; the next clean frame 0x5A is received correctly.
REQ-032 Scenario, with UART_RX_MAJORITY_EN: 0x81 with a 1-cycle inverted glitch on each sample cycle -> d_o=0x81; without the macro the same stimulus gives a corrupted byte or frame_err_o.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with a 2-flop input synchronizer.
// Each start/data/stop bit is sampled once, near the middle of its bit period.
// Optional build macro UART_RX_MAJORITY_EN: each bit sample becomes the 2-of-3 vote
// of rx_s over the sample cycle and the two cycles before it. The sample timing is
// the same in both builds.
module uart_rx #(
   parameter int unsigned CLKS_PER_BIT = 4
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       rx_i,
   output logic [7:0] d_o,
   output logic       v_o,
   output logic       frame_err_o,
   output logic       busy_o
);

   localparam int unsigned CntW = $clog2(CLKS_PER_BIT) + 1;
   // Loaded on the IDLE->START transition so the start check lands CLKS_PER_BIT/2
   // cycles after the cycle in which the falling edge is seen.
   localparam logic [CntW-1:0] HalfLoad = CntW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CntW-1:0] BitLoad  = CntW'(CLKS_PER_BIT - 1);
   localparam logic [CntW-1:0] LastBit  = CntW'(7);

   typedef enum logic [2:0] {
      StIdle     = 3'd0,
      StStart    = 3'd1,
      StData     = 3'd2,
      StStop     = 3'd3,
      StWaitIdle = 3'd4
   } state_e;

   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [CntW-1:0] bit_q, bit_d;
   logic [7:0]      shift_q, shift_d;
   logic [7:0]      data_q, data_d;
   logic            valid_q, valid_d;
   logic            ferr_q, ferr_d;
   logic            rx_meta_q, rx_s_q;
   logic            sample;

   // Two-flop synchronizer; the line idles high, so the flops reset to 1.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
      end else begin
         rx_meta_q <= rx_i;
         rx_s_q    <= rx_meta_q;
      end
   end

`ifdef UART_RX_MAJORITY_EN
   logic rx_h1_q, rx_h2_q;

   // Keep rx_s from the previous two cycles for the 2-of-3 vote.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rx_h1_q <= 1'b1;
         rx_h2_q <= 1'b1;
      end else begin
         rx_h1_q <= rx_s_q;
         rx_h2_q <= rx_h1_q;
      end
   end

   assign sample = (rx_h2_q & rx_h1_q) | (rx_h2_q & rx_s_q) | (rx_h1_q & rx_s_q);
`else
   assign sample = rx_s_q;
`endif

   // State, counters, shift register and the output registers.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= 8'h00;
         data_q  <= 8'h00;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
      end
   end

   // Frame sequencing: the timer counts down to the next sample point, then that
   // bit is acted on.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      data_d  = data_q;
      valid_d = 1'b0;
      ferr_d  = 1'b0;
      case (state_q)
         StIdle: begin
            if (!rx_s_q) begin
               state_d = StStart;
               cnt_d   = HalfLoad;
            end
         end
         StStart: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CntW'(1);
            end else if (sample) begin
               state_d = StIdle;
            end else begin
               state_d = StData;
               cnt_d   = BitLoad;
               bit_d   = '0;
            end
         end
         StData: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CntW'(1);
            end else begin
               // LSB arrives first: shift right and insert at the MSB.
               shift_d = {sample, shift_q[7:1]};
               cnt_d   = BitLoad;
               if (bit_q == LastBit) begin
                  state_d = StStop;
               end else begin
                  bit_d = bit_q + CntW'(1);
               end
            end
         end
         StStop: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CntW'(1);
            end else if (sample) begin
               data_d  = shift_q;
               valid_d = 1'b1;
               state_d = StIdle;
            end else begin
               ferr_d  = 1'b1;
               state_d = StWaitIdle;
            end
         end
         StWaitIdle: begin
            // A break keeps the line low; wait for it to return high.
            if (rx_s_q) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign d_o         = data_q;
   assign v_o         = valid_q;
   assign frame_err_o = ferr_q;
   assign busy_o      = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx (CLKS_PER_BIT = 4).
// The model works at the frame level. If rx_i falls in cycle F, it expects busy
// in cycles F+3..F+40, and in cycle F+41 either a v_o pulse with the byte or a
// frame_err_o pulse. A negedge process compares every output on every cycle.
module tb_uart_rx;
   localparam int unsigned Cpb    = 4;
   localparam int          MaxCyc = 2048;

   logic       clk;
   logic       resetn;
   logic       rx_i;
   logic [7:0] d_o;
   logic       v_o;
   logic       frame_err_o;
   logic       busy_o;

   uart_rx #(.CLKS_PER_BIT(Cpb)) dut (
      .clk         (clk),
      .resetn      (resetn),
      .rx_i        (rx_i),
      .d_o         (d_o),
      .v_o         (v_o),
      .frame_err_o (frame_err_o),
      .busy_o      (busy_o)
   );

   int       cyc = 0;
   int       n_checks = 0;
   int       n_pass = 0;
   bit       exp_v    [MaxCyc];
   bit       exp_ferr [MaxCyc];
   bit       exp_busy [MaxCyc];
   bit       exp_clr  [MaxCyc];
   bit [7:0] exp_d    [MaxCyc];
   bit [7:0] model_d = 8'h00;
   int       n_v = 0;
   int       n_ferr = 0;
   int       n_busy_cyc = 0;
   int       last_v_cyc = -1;
   int       prev_v_cyc = -1;
   bit [7:0] last_v_d = 8'h00;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", nm, cyc, act, exp);
   endtask

   // Per-cycle comparison against the frame-level model.
   always @(negedge clk) begin
      if (cyc < MaxCyc) begin
         if (exp_clr[cyc]) model_d = 8'h00;
         if (exp_v[cyc]) model_d = exp_d[cyc];
         chk("v_o", 32'(v_o), 32'(exp_v[cyc]));
         chk("frame_err_o", 32'(frame_err_o), 32'(exp_ferr[cyc]));
         chk("busy_o", 32'(busy_o), 32'(exp_busy[cyc]));
         chk("d_o", 32'(d_o), 32'(model_d));
      end
      chk("v_ferr_exclusive", 32'(v_o & frame_err_o), 32'(0));
      if (v_o) begin
         prev_v_cyc = last_v_cyc;
         last_v_cyc = cyc;
         last_v_d   = d_o;
         n_v++;
      end
      if (frame_err_o) n_ferr++;
      if (busy_o) n_busy_cyc++;
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic sched_busy(input int a, input int b);
      for (int c = a; c <= b; c++) if (c < MaxCyc) exp_busy[c] = 1'b1;
   endtask

   task automatic sched_frame(input int f, input bit [7:0] b, input bit ok);
      sched_busy(f + 3, f + 40);
      if (ok) begin
         exp_v[f + 41] = 1'b1;
         exp_d[f + 41] = b;
      end else begin
         exp_ferr[f + 41] = 1'b1;
      end
   endtask

   task automatic send_frame(input bit [7:0] b, input bit ok, output int f);
      f = cyc;
      sched_frame(f, b, ok);
      rx_i = 1'b0;
      tick(Cpb);
      for (int k = 0; k < 8; k++) begin
         rx_i = b[k];
         tick(Cpb);
      end
      rx_i = ok;
      tick(Cpb);
   endtask

   initial begin
      int       f;
      int       f2;
      int       nb;
      int       nv;
      int       nf;
      bit [7:0] pat;
      bit       bv;

      resetn = 1'b0;
      rx_i   = 1'b1;
      tick(3);
      chk("reset_d_o", 32'(d_o), 32'(8'h00));
      chk("reset_v_o", 32'(v_o), 32'(0));
      chk("reset_frame_err_o", 32'(frame_err_o), 32'(0));
      chk("reset_busy_o", 32'(busy_o), 32'(0));
      resetn = 1'b1;
      tick(4);

      // Single clean frame.
      send_frame(8'hA5, 1'b1, f);
      rx_i = 1'b1;
      tick(8);
      chk("a5_latency", 32'(last_v_cyc - f), 32'(41));
      chk("a5_data", 32'(last_v_d), 32'(8'hA5));
      chk("a5_no_ferr", 32'(n_ferr), 32'(0));

      // Back-to-back frames with no idle gap.
      send_frame(8'h00, 1'b1, f);
      send_frame(8'hFF, 1'b1, f2);
      rx_i = 1'b1;
      tick(8);
      chk("b2b_first_latency", 32'(prev_v_cyc - f), 32'(41));
      chk("b2b_spacing", 32'(last_v_cyc - prev_v_cyc), 32'(40));
      chk("b2b_second_start", 32'(f2 - f), 32'(40));
      chk("b2b_last_data", 32'(d_o), 32'(8'hFF));
      chk("b2b_pulse_count", 32'(n_v), 32'(3));

      // One-cycle low glitch on an idle line: false start.
      f  = cyc;
      sched_busy(f + 3, f + 4);
      nb = n_busy_cyc;
      nv = n_v;
      rx_i = 1'b0;
      tick(1);
      rx_i = 1'b1;
      tick(10);
      chk("glitch_busy_le4", 32'((n_busy_cyc - nb) <= 4), 32'(1));
      chk("glitch_no_v", 32'(n_v), 32'(nv));

      // Stop bit low, line held low for 20 cycles, then released.
      nf = n_ferr;
      nv = n_v;
      send_frame(8'h3C, 1'b0, f);
      sched_busy(f + 41, f + 58);
      rx_i = 1'b0;
      tick(16);
      rx_i = 1'b1;
      tick(10);
      chk("ferr_count", 32'(n_ferr - nf), 32'(1));
      chk("ferr_no_v", 32'(n_v), 32'(nv));
      chk("ferr_keeps_d", 32'(d_o), 32'(8'hFF));

      // Reset in the middle of data bit 3, with the line low at release.
      pat = 8'h99;
      f   = cyc;
      sched_busy(f + 3, f + 17);
      rx_i = 1'b0;
      tick(Cpb);
      for (int k = 0; k < 3; k++) begin
         rx_i = pat[k];
         tick(Cpb);
      end
      rx_i = pat[3];
      tick(2);
      exp_clr[cyc] = 1'b1;
      nv = n_v;
      nf = n_ferr;
      resetn = 1'b0;
      #1;
      chk("midrst_d_o", 32'(d_o), 32'(8'h00));
      chk("midrst_v_o", 32'(v_o), 32'(0));
      chk("midrst_frame_err_o", 32'(frame_err_o), 32'(0));
      chk("midrst_busy_o", 32'(busy_o), 32'(0));
      rx_i = 1'b0;
      tick(3);
      chk("midrst_no_pulses", 32'(n_v + n_ferr), 32'(nv + nf));
      resetn = 1'b1;
      send_frame(8'h5A, 1'b1, f);
      rx_i = 1'b1;
      tick(8);
      chk("post_rst_latency", 32'(last_v_cyc - f), 32'(41));
      chk("post_rst_data", 32'(last_v_d), 32'(8'h5A));

      // 0x81 with the third cycle of every bit inverted.
      pat = 8'h81;
      f   = cyc;
      nf  = n_ferr;
`ifdef UART_RX_MAJORITY_EN
      sched_frame(f, pat, 1'b1);
`else
      // Single-sample build: two false starts, then a frame locked to the wrong
      // edge. It samples bits 2..7, the stop bit and idle, giving 0xE0.
      sched_busy(f + 3, f + 4);
      sched_busy(f + 6, f + 7);
      sched_busy(f + 9, f + 46);
      exp_v[f + 47] = 1'b1;
      exp_d[f + 47] = 8'hE0;
`endif
      for (int j = 0; j < 10; j++) begin
         bv = (j == 0) ? 1'b0 : ((j == 9) ? 1'b1 : pat[j - 1]);
         rx_i = bv;
         tick(2);
         rx_i = ~bv;
         tick(1);
         rx_i = bv;
         tick(1);
      end
      rx_i = 1'b1;
      tick(12);
`ifdef UART_RX_MAJORITY_EN
      chk("maj_latency", 32'(last_v_cyc - f), 32'(41));
      chk("maj_data", 32'(last_v_d), 32'(8'h81));
`else
      chk("nomaj_latency", 32'(last_v_cyc - f), 32'(47));
      chk("nomaj_data", 32'(last_v_d), 32'(8'hE0));
`endif
      chk("glitchy_no_ferr", 32'(n_ferr), 32'(nf));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
